// File: rtl/writeback_cycle.sv
// Writeback stage of the RV32I pipeline: load alignment, result select, RF write, instret counter.
// Optional registered retire-trace port is compiled in with `define RETIRE_TRACE_EN.
module writeback_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidW,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcW,
  input  logic        MemReadW,
  input  logic        MemWriteW,
  input  logic [4:0]  RD_W,
  input  logic [31:0] InstrW,
  input  logic [31:0] PC_W,
  input  logic [31:0] PCPlus4W,
  input  logic [31:0] ALU_ResultW,
  input  logic [31:0] WriteDataW,
  input  logic [31:0] PCTargetW,
  input  logic        PCSrcW,
  input  logic [3:0]  dmem_mask_W,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_rvalid,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic [31:0] ResultW,
  output logic        o_stall,
  output logic [63:0] o_instret
`ifdef RETIRE_TRACE_EN
  ,
  output logic        o_retire_valid,
  output logic [31:0] o_retire_insn,
  output logic [31:0] o_retire_pc,
  output logic [31:0] o_retire_next_pc,
  output logic [4:0]  o_retire_rd,
  output logic [31:0] o_retire_rd_wdata,
  output logic [31:0] o_retire_mem_addr,
  output logic [3:0]  o_retire_mem_mask,
  output logic [31:0] o_retire_mem_rdata,
  output logic [31:0] o_retire_mem_wdata
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state;
  logic [63:0] r_instret;
  logic [31:0] w_sh;
  logic [31:0] w_load;
  logic [31:0] w_result;
  logic        w_ret;
  logic        w_rf_we;

  assign w_sh = i_dmem_rdata >> {ALU_ResultW[1:0], 3'b000};

  always_comb begin
    w_load = '0;
    case (InstrW[14:12])
      3'b000:  w_load = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_load = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b010:  w_load = w_sh;
      3'b100:  w_load = {24'b0, w_sh[7:0]};
      3'b101:  w_load = {16'b0, w_sh[15:0]};
      default: w_load = '0;
    endcase
  end

  always_comb begin
    w_result = ALU_ResultW;
    case (ResultSrcW)
      2'b01:   w_result = w_load;
      2'b10:   w_result = PCPlus4W;
      default: w_result = ALU_ResultW;
    endcase
  end

  // Stall is purely combinational so a same-cycle rvalid costs no bubble.
  assign o_stall    = ValidW & MemReadW & ~i_dmem_rvalid;
  assign w_ret      = ValidW & ~o_stall;
  assign w_rf_we    = w_ret & RegWriteW & (RD_W != 5'd0);
  assign o_rf_we    = w_rf_we;
  assign o_rf_waddr = RD_W;
  assign o_rf_wdata = w_result;
  assign ResultW    = w_result;
  assign o_instret  = r_instret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_instret <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (ValidW & MemReadW & ~i_dmem_rvalid) r_state <= S_WAIT;
        S_WAIT:  if (i_dmem_rvalid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_ret) r_instret <= r_instret + 64'd1;
    end
  end

`ifdef RETIRE_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_retire_valid     <= 1'b0;
      o_retire_insn      <= '0;
      o_retire_pc        <= '0;
      o_retire_next_pc   <= '0;
      o_retire_rd        <= '0;
      o_retire_rd_wdata  <= '0;
      o_retire_mem_addr  <= '0;
      o_retire_mem_mask  <= '0;
      o_retire_mem_rdata <= '0;
      o_retire_mem_wdata <= '0;
    end else begin
      o_retire_valid <= w_ret;
      if (w_ret) begin
        o_retire_insn      <= InstrW;
        o_retire_pc        <= PC_W;
        o_retire_next_pc   <= PCSrcW ? PCTargetW : PCPlus4W;
        o_retire_rd        <= w_rf_we ? RD_W : 5'd0;
        o_retire_rd_wdata  <= w_rf_we ? w_result : 32'd0;
        o_retire_mem_addr  <= (MemReadW | MemWriteW) ? {ALU_ResultW[31:2], 2'b00} : 32'd0;
        o_retire_mem_mask  <= (MemReadW | MemWriteW) ? dmem_mask_W : 4'd0;
        o_retire_mem_rdata <= MemReadW ? i_dmem_rdata : 32'd0;
        o_retire_mem_wdata <= MemWriteW ? WriteDataW : 32'd0;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{InstrW[31:15], InstrW[11:0], PC_W, WriteDataW, PCTargetW,
                      PCSrcW, dmem_mask_W, MemWriteW};
`endif

endmodule

// File: tb/tb_writeback_cycle.sv
// Directed bench for writeback_cycle; trace checks are included when RETIRE_TRACE_EN is defined.
module tb_writeback_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidW, RegWriteW, MemReadW, MemWriteW, PCSrcW, i_dmem_rvalid;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] InstrW, PC_W, PCPlus4W, ALU_ResultW, WriteDataW, PCTargetW, i_dmem_rdata;
  logic [3:0]  dmem_mask_W;
  logic        o_rf_we, o_stall;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata, ResultW;
  logic [63:0] o_instret;
`ifdef RETIRE_TRACE_EN
  logic        o_retire_valid;
  logic [31:0] o_retire_insn, o_retire_pc, o_retire_next_pc, o_retire_rd_wdata;
  logic [31:0] o_retire_mem_addr, o_retire_mem_rdata, o_retire_mem_wdata;
  logic [4:0]  o_retire_rd;
  logic [3:0]  o_retire_mem_mask;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] exp_cnt  = '0;

  always #5 clk = ~clk;

  writeback_cycle dut (
    .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .MemReadW(MemReadW), .MemWriteW(MemWriteW),
    .RD_W(RD_W), .InstrW(InstrW), .PC_W(PC_W), .PCPlus4W(PCPlus4W),
    .ALU_ResultW(ALU_ResultW), .WriteDataW(WriteDataW), .PCTargetW(PCTargetW),
    .PCSrcW(PCSrcW), .dmem_mask_W(dmem_mask_W), .i_dmem_rdata(i_dmem_rdata),
    .i_dmem_rvalid(i_dmem_rvalid), .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr),
    .o_rf_wdata(o_rf_wdata), .ResultW(ResultW), .o_stall(o_stall),
    .o_instret(o_instret)
`ifdef RETIRE_TRACE_EN
    ,
    .o_retire_valid(o_retire_valid), .o_retire_insn(o_retire_insn),
    .o_retire_pc(o_retire_pc), .o_retire_next_pc(o_retire_next_pc),
    .o_retire_rd(o_retire_rd), .o_retire_rd_wdata(o_retire_rd_wdata),
    .o_retire_mem_addr(o_retire_mem_addr), .o_retire_mem_mask(o_retire_mem_mask),
    .o_retire_mem_rdata(o_retire_mem_rdata), .o_retire_mem_wdata(o_retire_mem_wdata)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ValidW = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'b00; MemReadW = 1'b0;
    MemWriteW = 1'b0; RD_W = '0; InstrW = '0; PC_W = '0; PCPlus4W = '0;
    ALU_ResultW = '0; WriteDataW = '0; PCTargetW = '0; PCSrcW = 1'b0;
    dmem_mask_W = '0; i_dmem_rdata = '0; i_dmem_rvalid = 1'b0;
  endtask

  // Load in W with given funct3/address/read data/rvalid, targeting x5.
  task automatic load(input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] rdata, input logic rv);
    idle();
    ValidW = 1'b1; RegWriteW = 1'b1; ResultSrcW = 2'b01; MemReadW = 1'b1;
    RD_W = 5'd5; InstrW = {17'd0, f3, 12'h283}; PC_W = 32'h0000_1000;
    PCPlus4W = 32'h0000_1004; ALU_ResultW = addr; dmem_mask_W = 4'hF;
    i_dmem_rdata = rdata; i_dmem_rvalid = rv;
  endtask

  task automatic alu_op(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] val);
    idle();
    ValidW = 1'b1; RegWriteW = 1'b1; ResultSrcW = src; RD_W = rd;
    ALU_ResultW = val; PCPlus4W = 32'h0000_0044; InstrW = 32'h0000_0033;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } lvec_t;

  lvec_t lv [7];

  initial begin
    lv[0] = '{3'b000, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80};
    lv[1] = '{3'b101, 32'h0000_0202, 32'hBEEF_0001, 32'h0000_BEEF};
    lv[2] = '{3'b001, 32'h0000_0200, 32'h0000_8001, 32'hFFFF_8001};
    lv[3] = '{3'b010, 32'h0000_0300, 32'h1234_5678, 32'h1234_5678};
    lv[4] = '{3'b100, 32'h0000_0301, 32'h0000_AB00, 32'h0000_00AB};
    lv[5] = '{3'b000, 32'h0000_0302, 32'h0055_0000, 32'h0000_0055};
    lv[6] = '{3'b011, 32'h0000_0300, 32'hFFFF_FFFF, 32'h0000_0000};

    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_instret", o_instret, 64'd0);
    check("rst_stall", {63'd0, o_stall}, 64'd0);
    check("rst_we", {63'd0, o_rf_we}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (lv[i]) begin
      @(negedge clk);
      load(lv[i].f3, lv[i].addr, lv[i].rdata, 1'b1);
      #1;
      check($sformatf("load%0d_data", i), {32'd0, o_rf_wdata}, {32'd0, lv[i].exp});
      check($sformatf("load%0d_stall", i), {63'd0, o_stall}, 64'd0);
      check($sformatf("load%0d_we", i), {58'd0, o_rf_we, o_rf_waddr}, {58'd0, 1'b1, 5'd5});
      exp_cnt++;
      @(negedge clk);
      idle();
      #1;
      check($sformatf("load%0d_cnt", i), o_instret, exp_cnt);
`ifdef RETIRE_TRACE_EN
      check($sformatf("load%0d_tr_addr", i), {32'd0, o_retire_mem_addr},
            {32'd0, lv[i].addr[31:2], 2'b00});
      check($sformatf("load%0d_tr_wd", i), {32'd0, o_retire_rd_wdata}, {32'd0, lv[i].exp});
`endif
    end

    // ALU selects 00 and 11, ignoring a stray rvalid on a non-load
    @(negedge clk);
    alu_op(2'b00, 5'd7, 32'hDEAD_BEEF);
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1111_1111;
    #1;
    check("alu00", {32'd0, ResultW}, 64'hDEAD_BEEF);
    check("alu00_stall", {63'd0, o_stall}, 64'd0);
    exp_cnt++;
    @(negedge clk);
    alu_op(2'b11, 5'd7, 32'h0BAD_F00D);
    #1;
    check("alu11", {32'd0, o_rf_wdata}, 64'h0BAD_F00D);
    exp_cnt++;

    // Delayed response: three stall cycles, retire in rvalid cycle
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      load(3'b010, 32'h0000_0400, 32'hCAFE_0000, k == 3);
      #1;
      check($sformatf("dly%0d_stall", k), {63'd0, o_stall}, (k == 3) ? 64'd0 : 64'd1);
      check($sformatf("dly%0d_we", k), {63'd0, o_rf_we}, (k == 3) ? 64'd1 : 64'd0);
      check($sformatf("dly%0d_cnt", k), o_instret, exp_cnt);
    end
    exp_cnt++;

    // x0 destination: no write, still counts
    @(negedge clk);
    alu_op(2'b00, 5'd0, 32'h0000_0099);
    #1;
    check("x0_we", {63'd0, o_rf_we}, 64'd0);
    check("x0_cnt_pre", o_instret, exp_cnt);
    exp_cnt++;

    // Store: no stall even without rvalid
    @(negedge clk);
`ifdef RETIRE_TRACE_EN
    check("x0_tr_rd", {59'd0, o_retire_rd}, 64'd0);
    check("x0_tr_wd", {32'd0, o_retire_rd_wdata}, 64'd0);
`endif
    idle();
    ValidW = 1'b1; MemWriteW = 1'b1; ALU_ResultW = 32'h0000_0500;
    WriteDataW = 32'h5555_AAAA; dmem_mask_W = 4'h3;
    #1;
    check("st_stall", {63'd0, o_stall}, 64'd0);
    check("st_we", {63'd0, o_rf_we}, 64'd0);
    exp_cnt++;

    // Bubble: load-shaped but not valid
    @(negedge clk);
    load(3'b010, 32'h0, 32'h0, 1'b0);
    ValidW = 1'b0;
    #1;
    check("bub_stall", {63'd0, o_stall}, 64'd0);
    check("bub_we", {63'd0, o_rf_we}, 64'd0);
    check("st_cnt", o_instret, exp_cnt);

    // JAL
    @(negedge clk);
    idle();
    ValidW = 1'b1; RegWriteW = 1'b1; ResultSrcW = 2'b10; RD_W = 5'd1;
    PCPlus4W = 32'h0000_2004; PCSrcW = 1'b1; PCTargetW = 32'h0000_3000;
    ALU_ResultW = 32'h0000_3000; PC_W = 32'h0000_2000; InstrW = 32'h0000_006F;
    #1;
    check("jal_wdata", {32'd0, o_rf_wdata}, 64'h2004);
    exp_cnt++;
    @(negedge clk);
    idle();
    #1;
    check("jal_cnt", o_instret, exp_cnt);
`ifdef RETIRE_TRACE_EN
    check("jal_tr_npc", {32'd0, o_retire_next_pc}, 64'h3000);
    check("jal_tr_valid", {63'd0, o_retire_valid}, 64'd1);
`endif

    // Reset mid-WAIT, with rvalid arriving in the reset cycle
    @(negedge clk);
    load(3'b010, 32'h0000_0600, 32'h7777_7777, 1'b0);
    #1;
    check("rw_stall", {63'd0, o_stall}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    load(3'b010, 32'h0000_0600, 32'h7777_7777, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    check("rw_cnt", o_instret, 64'd0);
`ifdef RETIRE_TRACE_EN
    check("rw_tr_valid", {63'd0, o_retire_valid}, 64'd0);
`endif
    exp_cnt = 64'd0;

    // Post-reset: a new load with same-cycle rvalid retires cleanly
    @(negedge clk);
    load(3'b000, 32'h0000_0001, 32'h0000_7F00, 1'b1);
    #1;
    check("post_stall", {63'd0, o_stall}, 64'd0);
    check("post_data", {32'd0, o_rf_wdata}, 64'h7F);
    exp_cnt++;
    @(negedge clk);
    idle();
    #1;
    check("post_cnt", o_instret, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
